// File: rtl/host_line_responder.sv
// -----------------------------------------------------------------------------
// host_line_responder
//
// Host-side responder for the memory controller's cache-line port. Serves
// host_re / host_we requests from a DEPTH-line backing store. It clears the
// store after reset and then raises host_init. A read stages one line on a
// registered bus. A write commits one line after a fixed latency.
//
// Optional feature macro: HOST_RESP_OOR_EN
//   defined   : addresses with bits set above the line-index field are out of
//               range. Such reads stage a zero line, such writes leave memory
//               untouched, and either one sets the sticky oor_err flag.
//   undefined : upper address bits are ignored (lines alias modulo DEPTH) and
//               oor_err stays 0.
//
// Ports
//   clk                      in   sole clock, rising edge
//   rst_n                    in   synchronous active-low reset
//   corrected_address        in   byte address; line index = addr[6 +: log2(DEPTH)]
//   host_re                  in   pop the staged line (only while host_rd_ready)
//   host_we                  in   write request (only while host_wr_ready)
//   host_data_bus_write_out  in   write line, sampled with an accepted host_we
//   host_init                out  store cleared, responder live (sticky)
//   host_rd_ready            out  staged line valid on host_data_bus_read_in
//   host_data_bus_read_in    out  staged read line (registered)
//   host_wr_ready            out  write channel can accept
//   oor_err                  out  sticky out-of-range flag
// -----------------------------------------------------------------------------
module host_line_responder #(
  parameter int ADDR_BITCOUNT = 64,
  parameter int CL_SIZE_WIDTH = 512,
  parameter int DEPTH         = 16,
  parameter int RD_LATENCY    = 4,
  parameter int WR_LATENCY    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_BITCOUNT-1:0] corrected_address,
  input  logic                     host_re,
  input  logic                     host_we,
  input  logic [CL_SIZE_WIDTH-1:0] host_data_bus_write_out,
  output logic                     host_init,
  output logic                     host_rd_ready,
  output logic [CL_SIZE_WIDTH-1:0] host_data_bus_read_in,
  output logic                     host_wr_ready,
  output logic                     oor_err
);

  localparam int IDX_W    = $clog2(DEPTH);
  localparam int IDX_LSB  = 6;
  localparam int IDX_TOP  = IDX_LSB + IDX_W;
  localparam int RD_CNT_W = $clog2(RD_LATENCY + 1);
  localparam int WR_CNT_W = $clog2(WR_LATENCY + 1);

  localparam logic [RD_CNT_W-1:0] RD_LOAD  = RD_CNT_W'(RD_LATENCY - 1);
  localparam logic [WR_CNT_W-1:0] WR_LOAD  = WR_CNT_W'(WR_LATENCY - 1);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {INIT, IDLE, FETCH, STAGED} rd_state_e;
  typedef enum logic       {WIDLE, WBUSY}              wr_state_e;

  // Registered state
  rd_state_e                r_rd_state;
  logic [RD_CNT_W-1:0]      r_rd_cnt;
  logic [IDX_W-1:0]         r_rd_idx;
  logic                     r_rd_oor;
  logic                     r_rd_ready;
  logic [CL_SIZE_WIDTH-1:0] r_rd_data;
  logic [IDX_W-1:0]         r_clr_cnt;
  logic                     r_init;
  wr_state_e                r_wr_state;
  logic [WR_CNT_W-1:0]      r_wr_cnt;
  logic [IDX_W-1:0]         r_wr_idx;
  logic                     r_wr_oor;
  logic [CL_SIZE_WIDTH-1:0] r_wr_data;
  logic                     r_wr_ready;
  logic                     r_oor_err;

  logic [CL_SIZE_WIDTH-1:0] r_mem [DEPTH];

  // Next-state values
  rd_state_e                w_rd_state_d;
  logic [RD_CNT_W-1:0]      w_rd_cnt_d;
  logic [IDX_W-1:0]         w_rd_idx_d;
  logic                     w_rd_oor_d;
  logic                     w_rd_ready_d;
  logic [CL_SIZE_WIDTH-1:0] w_rd_data_d;
  logic [IDX_W-1:0]         w_clr_cnt_d;
  logic                     w_init_d;
  wr_state_e                w_wr_state_d;
  logic [WR_CNT_W-1:0]      w_wr_cnt_d;
  logic [IDX_W-1:0]         w_wr_idx_d;
  logic                     w_wr_oor_d;
  logic [CL_SIZE_WIDTH-1:0] w_wr_data_d;
  logic                     w_oor_err_d;

  // Decoded request and memory write port
  logic [IDX_W-1:0]         w_live_idx;
  logic                     w_live_oor;
  logic                     w_wr_accept;
  logic                     w_wr_commit;
  logic                     w_raw_hit;
  logic                     w_rd_abandon;
  logic                     w_mem_we;
  logic [IDX_W-1:0]         w_mem_idx;
  logic [CL_SIZE_WIDTH-1:0] w_mem_data;

  assign w_live_idx = corrected_address[IDX_LSB +: IDX_W];

`ifdef HOST_RESP_OOR_EN
  logic [IDX_LSB-1:0] w_unused_addr_bits;
  assign w_unused_addr_bits = corrected_address[IDX_LSB-1:0];
  assign w_live_oor         = |corrected_address[ADDR_BITCOUNT-1:IDX_TOP];
`else
  logic [ADDR_BITCOUNT-IDX_TOP+IDX_LSB-1:0] w_unused_addr_bits;
  assign w_unused_addr_bits = {corrected_address[ADDR_BITCOUNT-1:IDX_TOP],
                               corrected_address[IDX_LSB-1:0]};
  assign w_live_oor         = 1'b0;
`endif

  // r_wr_ready already encodes (WIDLE && host_init), so it doubles as the accept gate.
  assign w_wr_accept = r_wr_ready && host_we;
  assign w_wr_commit = (r_wr_state == WBUSY) && (r_wr_cnt == '0);

  // A commit that lands on the line being fetched or presented makes it stale.
  // Out-of-range writes never reach memory and out-of-range reads are zero
  // lines, so neither side can be stale.
  assign w_raw_hit    = w_wr_commit && !r_wr_oor && !r_rd_oor && (r_wr_idx == r_rd_idx);
  assign w_rd_abandon = (w_live_idx != r_rd_idx) || (w_live_oor != r_rd_oor) || w_raw_hit;

  // Single memory write port: the INIT sweep and write commits never overlap,
  // because the write channel stays closed until host_init rises. Gating with
  // rst_n drops a commit that coincides with reset.
  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_idx  = r_clr_cnt;
    w_mem_data = '0;
    if (r_rd_state == INIT) begin
      w_mem_we = rst_n;
    end else if (w_wr_commit && !r_wr_oor) begin
      w_mem_we   = rst_n;
      w_mem_idx  = r_wr_idx;
      w_mem_data = r_wr_data;
    end
  end

  // NOTE: every signal gets its hold value first, so no path leaves one
  // unassigned and no latch can be inferred.
  always_comb begin
    w_rd_state_d = r_rd_state;
    w_rd_cnt_d   = r_rd_cnt;
    w_rd_idx_d   = r_rd_idx;
    w_rd_oor_d   = r_rd_oor;
    w_rd_ready_d = r_rd_ready;
    w_rd_data_d  = r_rd_data;
    w_clr_cnt_d  = r_clr_cnt;
    w_init_d     = r_init;
    w_wr_state_d = r_wr_state;
    w_wr_cnt_d   = r_wr_cnt;
    w_wr_idx_d   = r_wr_idx;
    w_wr_oor_d   = r_wr_oor;
    w_wr_data_d  = r_wr_data;
    w_oor_err_d  = r_oor_err;

    // Read side
    unique case (r_rd_state)
      INIT: begin
        w_clr_cnt_d = r_clr_cnt + IDX_W'(1);
        if (r_clr_cnt == LAST_IDX) begin
          w_rd_state_d = IDLE;
          w_init_d     = 1'b1;
        end
      end
      IDLE: begin
        w_rd_idx_d   = w_live_idx;
        w_rd_oor_d   = w_live_oor;
        w_rd_cnt_d   = RD_LOAD;
        w_rd_state_d = FETCH;
        if (w_live_oor) w_oor_err_d = 1'b1;
      end
      FETCH: begin
        if (w_rd_abandon) begin
          w_rd_state_d = IDLE;
        end else if (r_rd_cnt == '0) begin
          w_rd_data_d  = r_rd_oor ? '0 : r_mem[r_rd_idx];
          w_rd_ready_d = 1'b1;
          w_rd_state_d = STAGED;
        end else begin
          w_rd_cnt_d = r_rd_cnt - RD_CNT_W'(1);
        end
      end
      STAGED: begin
        // Popped or abandoned: the bus keeps its last value, only ready drops.
        if (host_re || w_rd_abandon) begin
          w_rd_ready_d = 1'b0;
          w_rd_state_d = IDLE;
        end
      end
      default: w_rd_state_d = INIT;
    endcase

    // Write side
    unique case (r_wr_state)
      WIDLE: begin
        if (w_wr_accept) begin
          w_wr_idx_d   = w_live_idx;
          w_wr_oor_d   = w_live_oor;
          w_wr_data_d  = host_data_bus_write_out;
          w_wr_cnt_d   = WR_LOAD;
          w_wr_state_d = WBUSY;
          if (w_live_oor) w_oor_err_d = 1'b1;
        end
      end
      WBUSY: begin
        if (r_wr_cnt == '0) w_wr_state_d = WIDLE;
        else                w_wr_cnt_d   = r_wr_cnt - WR_CNT_W'(1);
      end
      default: w_wr_state_d = WIDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_state <= INIT;
      r_rd_cnt   <= '0;
      r_rd_idx   <= '0;
      r_rd_oor   <= 1'b0;
      r_rd_ready <= 1'b0;
      r_rd_data  <= '0;
      r_clr_cnt  <= '0;
      r_init     <= 1'b0;
      r_wr_state <= WIDLE;
      r_wr_cnt   <= '0;
      r_wr_idx   <= '0;
      r_wr_oor   <= 1'b0;
      r_wr_data  <= '0;
      r_wr_ready <= 1'b0;
      r_oor_err  <= 1'b0;
    end else begin
      r_rd_state <= w_rd_state_d;
      r_rd_cnt   <= w_rd_cnt_d;
      r_rd_idx   <= w_rd_idx_d;
      r_rd_oor   <= w_rd_oor_d;
      r_rd_ready <= w_rd_ready_d;
      r_rd_data  <= w_rd_data_d;
      r_clr_cnt  <= w_clr_cnt_d;
      r_init     <= w_init_d;
      r_wr_state <= w_wr_state_d;
      r_wr_cnt   <= w_wr_cnt_d;
      r_wr_idx   <= w_wr_idx_d;
      r_wr_oor   <= w_wr_oor_d;
      r_wr_data  <= w_wr_data_d;
      r_wr_ready <= (w_wr_state_d == WIDLE) && w_init_d;
      r_oor_err  <= w_oor_err_d;
    end
  end

  // NOTE: the store has no reset; the INIT sweep zeroes it line by line,
  // which keeps the array mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_idx] <= w_mem_data;
  end

  assign host_init             = r_init;
  assign host_rd_ready         = r_rd_ready;
  assign host_data_bus_read_in = r_rd_data;
  assign host_wr_ready         = r_wr_ready;
  assign oor_err               = r_oor_err;

endmodule

// File: doc/host_line_responder.md
# host_line_responder

Host-side responder for the memory controller's cache-line port: it answers the controller's `host_re` / `host_we` requests from a DEPTH-line backing store. It stages one 512-bit line for reads and commits one line per write. It also generates `host_init` once its store is cleared. It sits between `mem_ctrl` and the host memory. In simulation and early bring-up it stands in for the real host link.

## Interface
- `ADDR_BITCOUNT`, 64, width of `corrected_address`
- `CL_SIZE_WIDTH`, 512, cache-line width in bits
- `DEPTH`, 16, number of lines stored; power of two, ≥2
- `RD_LATENCY`, 4, cycles from address sample to staged line valid; ≥1
- `WR_LATENCY`, 2, cycles from write accept to memory commit; ≥1

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `corrected_address`  in  ADDR_BITCOUNT  byte address of request; line index = `corrected_address[6 +: $clog2(DEPTH)]`; bits [5:0] ignored
- `host_re`  in  1  pop staged read line; honoured only while `host_rd_ready`
- `host_we`  in  1  write request; honoured only while `host_wr_ready`
- `host_data_bus_write_out`  in  CL_SIZE_WIDTH  line to write, sampled with accepted `host_we`
- `host_init`  out  1  store cleared, responder live
- `host_rd_ready`  out  1  staged line valid on `host_data_bus_read_in`
- `host_data_bus_read_in`  out  CL_SIZE_WIDTH  staged read line, registered
- `host_wr_ready`  out  1  write channel can accept
- `oor_err`  out  1  sticky out-of-range flag (see Configuration)

## Operation
- Reset values:
  - every output is 0;
  - read FSM resets to INIT;
  - write FSM resets to WIDLE;
  - the clear counter resets to 0.
- INIT:
  - writes zero to line `clr_cnt` each cycle, DEPTH cycles in total.
  - Then moves to IDLE and sets `host_init`=1; `host_init` then stays 1 until reset.
  - `host_wr_ready`=0 throughout INIT.
- Read FSM, states IDLE → FETCH → STAGED:
  - IDLE: sample the line index from `corrected_address`, load the latency counter with RD_LATENCY-1, go to FETCH.
  - FETCH: decrement the counter. At 0, register `mem[idx]` into `host_data_bus_read_in`, set `host_rd_ready`=1, go to STAGED.
  - STAGED, with `host_re`=1: clear `host_rd_ready` and go to IDLE. The data bus holds its last value.
  - STAGED or FETCH, when the live index ≠ the latched index: abandon the line. Clear `host_rd_ready` and go to IDLE, which refetches.
- Write FSM, states WIDLE / WBUSY:
  - `host_wr_ready` = (state==WIDLE && `host_init`).
  - Accept `host_we`: latch the index and data, clear `host_wr_ready`, go to WBUSY.
  - After WR_LATENCY cycles, write `mem[idx]` and return to WIDLE.
  - `host_we` while not ready is ignored, with no side effect.
- Read-after-write hazard: a write commit whose index equals the FETCH/STAGED latched index invalidates the read. `host_rd_ready` clears and the read FSM goes to IDLE, so stale lines are never presented.
- Simultaneous `host_re` and `host_we` are both accepted in the same cycle.
- Reset mid-operation: a pending write is dropped, the staged line is dropped, and INIT reruns in full.

## Timing
- Read latency:
  - address sampled at edge E; `host_rd_ready`=1 and data valid after edge E+RD_LATENCY.
  - Pop at edge P: `host_rd_ready`=0 after P; next sample at P+1; next ready after P+1+RD_LATENCY.
- Write: accept at edge W; commit at edge W+WR_LATENCY; `host_wr_ready`=1 again after the same edge.
- Back-to-back writes: one per WR_LATENCY+1 cycles.
- `host_init` rises after edge DEPTH following reset release, i.e. 16 cycles with defaults.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `HOST_RESP_OOR_EN` defined:
  - a request is out of range when any address bit above the index field, i.e. bit 6+$clog2(DEPTH) and up, is set.
  - An out-of-range read stages an all-zero line with normal timing.
  - An out-of-range write is accepted with normal timing, but memory is not modified.
  - Either case sets `oor_err`=1, sticky until reset.
- Not defined: upper bits are ignored, so addresses alias modulo DEPTH lines; `oor_err` is tied to 0.

## Test plan
- Reset held 5 cycles, then released → all outputs 0 during reset; `host_init`=1 exactly 16 cycles later; `host_wr_ready`=1 together with `host_init`.
- Write 0xA5…A5 to address 0x40, then read address 0x40 → `host_wr_ready` low for 2 cycles; after refetch, `host_rd_ready` rises 4 cycles after sample with data 0xA5…A5; address 0x80 reads 0.
- Staged line at 0x40, change `corrected_address` to 0x80 with no pop → `host_rd_ready` drops next cycle; rises 4+1 cycles later with line 2's contents.
- Line 1 staged, commit write to 0x40 with 0x1234 → `host_rd_ready` drops at commit; restaged value = 0x1234.
- `host_re` and `host_we` both 1 in one cycle → both accepted; pop honoured; write commits 2 cycles later.
- With `HOST_RESP_OOR_EN`, read 0x400 (DEPTH=16) → zero line staged, `oor_err`=1 and held; without the macro, same read returns line 0 and `oor_err`=0.
